// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Brief    : Shared constants and types for the clock/timer/stopwatch display path.
// Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

    localparam int unsigned MS_PER_DAY = 32'd86_400_000;

    // Place weights for h1 h0 m1 m0 s1 s0 k2 k1; k0 is the final remainder.
    localparam int unsigned WEIGHTS [0:7] = '{
        32'd36_000_000, 32'd3_600_000, 32'd600_000, 32'd60_000,
        32'd10_000,     32'd1_000,     32'd100,     32'd10
    };

    typedef logic [3:0] bcd_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ms_to_bcd_time.sv
`default_nettype none
// ============================================================================
// Module   : ms_to_bcd_time
// Brief    : Iterative binary-ms to h1 h0:m1 m0:s1 s0.k2 k1 k0 BCD converter,
//            one weighted compare/subtract per cycle. Optional range check
//            enabled by defining MS_TO_BCD_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ms_to_bcd_time
    import clock_pkg::*;
#(
    parameter int MS_W = 27
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [MS_W-1:0] ms_in,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [3:0]      h1,
    output logic [3:0]      h0,
    output logic [3:0]      m1,
    output logic [3:0]      m0,
    output logic [3:0]      s1,
    output logic [3:0]      s0,
    output logic [3:0]      k2,
    output logic [3:0]      k1,
    output logic [3:0]      k0
);

    localparam logic [2:0] c_last_idx = 3'd7;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [MS_W-1:0] r_rem;
    logic [MS_W-1:0] w_weight;
    logic [2:0]      r_idx;
    bcd_t            r_acc;
    bcd_t            r_stage [0:8];
    bcd_t            r_dig   [0:8];
    logic            r_pend;
    logic            r_done;
    logic            w_ge;
    logic            w_last;
    logic            w_accept;
    logic            w_ovf;

    assign w_weight = MS_W'(WEIGHTS[r_idx]);
    assign w_ge     = (r_rem >= w_weight);
    assign w_last   = (r_idx == c_last_idx);
    assign w_accept = (r_state == ST_IDLE) && start;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start && !w_ovf)   w_state_nxt = ST_CONV;
            ST_CONV: if (!w_ge && w_last)   w_state_nxt = ST_IDLE;
        endcase
    end

    // Results collect in r_stage and are published one edge after the last
    // compare, so the digit outputs always switch as one complete time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rem  <= '0;
            r_idx  <= '0;
            r_acc  <= '0;
            r_pend <= 1'b0;
            r_done <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_stage[i] <= '0;
                r_dig[i]   <= '0;
            end
        end else begin
            r_pend <= 1'b0;
            r_done <= r_pend;
            if (r_pend) begin
                r_dig <= r_stage;
            end
            if (w_accept) begin
                r_rem <= ms_in;
                r_idx <= '0;
                r_acc <= '0;
                if (w_ovf) begin
                    for (int i = 0; i < 9; i++) begin
                        r_stage[i] <= '0;
                    end
                    r_pend <= 1'b1;
                end
            end else if (r_state == ST_CONV) begin
                if (w_ge) begin
                    r_rem <= r_rem - w_weight;
                    r_acc <= r_acc + 4'd1;
                end else begin
                    r_stage[{1'b0, r_idx}] <= r_acc;
                    r_acc <= '0;
                    r_idx <= r_idx + 3'd1;
                    if (w_last) begin
                        r_stage[8] <= r_rem[3:0];
                        r_pend     <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef MS_TO_BCD_OVF_EN
    logic r_err;

    assign w_ovf = (ms_in >= MS_W'(MS_PER_DAY));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_ovf;
        end
    end

    assign err = r_err;
`else
    assign w_ovf = 1'b0;
    assign err   = 1'b0;
`endif

    assign busy = (r_state == ST_CONV);
    assign done = r_done;
    assign h1   = r_dig[0];
    assign h0   = r_dig[1];
    assign m1   = r_dig[2];
    assign m0   = r_dig[3];
    assign s1   = r_dig[4];
    assign s0   = r_dig[5];
    assign k2   = r_dig[6];
    assign k1   = r_dig[7];
    assign k0   = r_dig[8];

endmodule
`default_nettype wire

// File: tb/tb_ms_to_bcd_time.sv
`default_nettype none
// ============================================================================
// Module   : tb_ms_to_bcd_time
// Brief    : Self-checking bench for ms_to_bcd_time with a div/mod timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ms_to_bcd_time;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [26:0] ms_in;
    logic        busy, done, err;
    logic [3:0]  h1, h0, m1, m0, s1, s0, k2, k1, k0;
    logic [35:0] dut_dig;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: expected busy window, done cycle and published digits.
    int          busy_lo = 0;
    int          busy_hi = -1;
    int          done_at = -1;
    logic [35:0] m_dig   = '0;
    logic [35:0] m_next  = '0;
    logic        m_err   = 1'b0;

    always #5 CLK = ~CLK;

    assign dut_dig = {h1, h0, m1, m0, s1, s0, k2, k1, k0};

    ms_to_bcd_time #(.MS_W(27)) dut (
        .CLK(CLK), .RST(RST), .start(start), .ms_in(ms_in),
        .busy(busy), .done(done), .err(err),
        .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
        .k2(k2), .k1(k1), .k0(k0)
    );

    function automatic logic [35:0] ref_digits(input int unsigned ms);
        int unsigned h, m, s, k;
        h = ms / 3600000;
        m = (ms / 60000) % 60;
        s = (ms / 1000) % 60;
        k = ms % 1000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(k / 100), 4'((k / 10) % 10), 4'(k % 10)};
    endfunction

    function automatic int digit_sum(input logic [35:0] d);
        int sum = 0;
        for (int i = 1; i < 9; i++) sum += int'(d[i*4 +: 4]);
        return sum;
    endfunction

    function automatic logic is_ovf(input int unsigned ms);
`ifdef MS_TO_BCD_OVF_EN
        return (ms >= 32'd86_400_000);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_latency(input int unsigned ms);
        if (is_ovf(ms)) return 1;
        return 9 + digit_sum(ref_digits(ms));
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask

    // Reference timeline, advanced on every active edge from the inputs alone.
    always @(posedge CLK) begin
        int unsigned ms;
        logic [35:0] d;
        int          s;
        cyc = cyc + 1;
        if (RST) begin
            busy_lo = 0; busy_hi = -1; done_at = -1;
            m_dig = '0; m_next = '0; m_err = 1'b0;
        end else begin
            if (cyc == done_at) m_dig = m_next;
            if (start && !((cyc - 1) >= busy_lo && (cyc - 1) <= busy_hi)) begin
                ms = int'(ms_in);
                if (is_ovf(ms)) begin
                    m_next = '0; m_err = 1'b1;
                    busy_lo = 0; busy_hi = -1; done_at = cyc + 1;
                end else begin
                    d = ref_digits(ms);
                    s = digit_sum(d);
                    m_next = d; m_err = 1'b0;
                    busy_lo = cyc; busy_hi = cyc + 7 + s; done_at = cyc + 9 + s;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (cyc >= 1) begin
            check("digits", 64'(dut_dig), 64'(m_dig));
            check("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
            check("done", 64'(done), 64'(cyc == done_at));
            check("err", 64'(err), 64'(m_err));
        end
    end

    task automatic pulse_start(input logic [26:0] v);
        start = 1'b1;
        ms_in = v;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Returns the cycle in which done is seen and the busy cycles counted from entry.
    task automatic wait_done(input int budget, output int dcyc, output int bcnt);
        dcyc = -1;
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < budget && dcyc < 0; i++) begin
            @(negedge CLK);
            if (done === 1'b1) dcyc = cyc;
            else if (busy === 1'b1) bcnt++;
        end
        if (dcyc < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout at cycle %0d: got no done want done within %0d cycles", cyc, budget);
        end
    endtask

    initial begin
        int e, d, bc, n;
        logic [26:0] v;
        RST = 1'b1; start = 1'b0; ms_in = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("rst_digits", 64'(dut_dig), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_err", 64'(err), 64'h0);

        pulse_start(27'd0); e = cyc;
        wait_done(30, d, bc);
        check("zero_latency", 64'(d - e), 64'd9);
        check("zero_busy_cycles", 64'(bc), 64'd8);
        check("zero_digits", 64'(dut_dig), 64'h0);

        pulse_start(27'd45_296_789); e = cyc;
        repeat (4) @(negedge CLK);
        pulse_start(27'd7);
        ms_in = 27'd99_999;
        wait_done(80, d, bc);
        check("mid_latency", 64'(d - e), 64'd45);
        check("mid_digits", 64'(dut_dig), 64'h123456789);

        pulse_start(27'd86_399_999); e = cyc;
        wait_done(100, d, bc);
        check("max_latency", 64'(d - e), 64'd60);
        check("max_busy_cycles", 64'(bc), 64'd59);
        check("max_digits", 64'(dut_dig), 64'h235959999);
        pulse_start(27'd0); e = cyc;
        check("b2b_accept_edge", 64'(e - d), 64'd1);
        wait_done(30, d, bc);
        check("b2b_latency", 64'(d - e), 64'd9);
        check("b2b_digits", 64'(dut_dig), 64'h0);

        pulse_start(27'd12_345_678); e = cyc;
        wait_done(80, d, bc);
        check("t12_latency", 64'(d - e), 64'd41);
        check("t12_digits", 64'(dut_dig), 64'h032545678);

        pulse_start(27'd45_296_789); e = cyc;
        repeat (19) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_digits", 64'(dut_dig), 64'h0);
        n = 0;
        repeat (60) begin
            @(negedge CLK);
            if (done) n++;
        end
        check("abort_no_done", 64'(n), 64'd0);

        pulse_start(27'd100_000_000); e = cyc;
        wait_done(80, d, bc);
`ifdef MS_TO_BCD_OVF_EN
        check("ovf_latency", 64'(d - e), 64'd1);
        check("ovf_err", 64'(err), 64'd1);
        check("ovf_digits", 64'(dut_dig), 64'h0);
`else
        check("wide_latency", 64'(d - e), 64'd32);
        check("wide_err", 64'(err), 64'd0);
        check("wide_digits", 64'(dut_dig), 64'h274640000);
`endif

        for (int i = 0; i < 1050; i++) begin
            v = (i < 1000) ? 27'($urandom_range(0, 86_399_999))
                           : 27'($urandom_range(0, 134_217_727));
            pulse_start(v); e = cyc;
            ms_in = 27'($urandom);
            if (!is_ovf(int'(v)) && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 6)) @(negedge CLK);
                pulse_start(27'($urandom));
            end
            wait_done(100, d, bc);
            check("rand_latency", 64'(d - e), 64'(exp_latency(int'(v))));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ms_to_bcd_time.md
# ms_to_bcd_time

Sequential converter from a binary millisecond count to the nine BCD time digits (h1 h0 : m1 m0 : s1 s0 . k2 k1 k0) used by the display path. It is the inverse of the existing digit-to-segment decode: counters kept in plain binary ms feed this block, and its digit outputs drive the same mode mux and `bcd_to_number` decoder as the clock, timer and stopwatch digits. It uses iterative weighted subtraction, one compare per cycle, with a start/busy/done handshake.

## Interface
- `MS_W`, 27, width of the binary input. 2^27 is greater than 86,400,000.
- `CLK` in 1: system clock. One clock domain.
- `RST` in 1: reset. Synchronous and active-high.
- `start` in 1: request conversion of `ms_in`. Sampled only in IDLE.
- `ms_in` in MS_W: binary milliseconds. Sampled on the edge that accepts `start`.
- `busy` out 1: high while a conversion is running.
- `done` out 1: one-cycle pulse when the result is valid.
- `err` out 1: out-of-range flag. Exists only under `MS_TO_BCD_OVF_EN`; otherwise tied 0.
- `h1 h0 m1 m0 s1 s0 k2 k1 k0` out 4 each: BCD digits, held between conversions.

## Operation
- States:
  - IDLE: `busy`=0.
  - CONV: `busy`=1.
- Reset values: state IDLE, all digits 0, `busy`/`done`/`err` 0.
- Weight table, index 0..7: 36,000,000; 3,600,000; 600,000; 60,000; 10,000; 1,000; 100; 10.
- IDLE with `start`=1:
  - rem <= `ms_in`, idx <= 0, digit accumulator <= 0.
  - Go to CONV.
- Each CONV cycle:
  - If rem >= W[idx]: rem -= W[idx] and acc++.
  - Else: write acc to digit[idx], acc <= 0, idx++.
- On the failing compare at idx=7:
  - Write k1 <= acc and k0 <= rem[3:0].
  - Return to IDLE and pulse `done` for one cycle.
- Digit commit: the published digit outputs change only on the `done` edge. Per-digit results are staged internally, so outputs never show a half-updated time.
- Arithmetic: rem and the compare are MS_W bits unsigned. acc is 4 bits. W[0] can be subtracted at most 3 times for a 27-bit input, so no digit exceeds 9 except h1. h1 is at most 3 when the range check is compiled out.
- Boundary rules:
  - `start` while `busy`: ignored, and the conversion in flight is unaffected.
  - `start` in the cycle `done` is high: accepted, because the state is already IDLE.
  - `RST` mid-conversion: back to IDLE on the next edge, digits cleared, no `done`.
  - `ms_in` changing during CONV: no effect, since the value was captured at start.

## Timing
- Let S = h1+h0+m1+m0+s1+s0+k2+k1 of the result.
- `done` is high during the cycle that follows edge E+9+S, where E is the edge that sampled `start`.
- `busy` covers exactly the preceding 8+S cycles.
- Latency bounds:
  - Minimum: 9 edges, for `ms_in`=0.
  - Maximum in range: 60 edges, for 86,399,999.
- Throughput: one conversion per 9+S cycles. Back-to-back starts are allowed.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `MS_TO_BCD_OVF_EN` defined:
  - IDLE compares `ms_in` >= 86,400,000 on the start edge.
  - If out of range: skip CONV, set all digits 0, `err`=1, and `done` follows after 1 edge.
  - `err` is cleared by the next accepted start or by `RST`.
- `MS_TO_BCD_OVF_EN` not defined:
  - No range check; `err` is constant 0.
  - Inputs up to 2^27-1 convert to h1 <= 3 with all other digits valid.

## Structure
- Shared package `clock_pkg` holds:
  - `MS_PER_DAY` = 86,400,000.
  - The 8-entry weight array as a constant.
  - A `bcd_t` 4-bit digit typedef.
  - The state enum.
- One module with no sub-module. The compare/subtract step is a single datapath inside the FSM.

## Test plan
- `ms_in`=0, start: all digits 0; `done` at edge E+9; `busy` high for 8 cycles.
- `ms_in`=45,296,789, start: digits 1,2,3,4,5,6,7,8,9; `done` at E+45.
- `ms_in`=86,399,999: digits 2,3,5,9,5,9,9,9,9; `done` at E+60. Start asserted again in the `done` cycle with 0: accepted, and all-zero digits follow 9 edges later.
- Pulse `start` at E+5 during the 45,296,789 conversion: ignored, result and timing unchanged. Assert `RST` at E+20 of a new conversion: IDLE next edge, digits 0, no `done`.
- `ms_in`=100,000,000:
  - With the macro: `err`=1, digits 0, `done` at E+1.
  - Without the macro: digits 2,7,4,6,4,0,0,0,0 (27:46:40.000), `err`=0.
- Random in-range inputs (1000 samples) checked against a reference div/mod model, including digit values and `done` latency of 9+S.
